// File: rtl/lsu_mmio.sv
// lsu_mmio: MEM-stage load/store unit. Serves B/H/W loads and stores with
// sign/zero extension against a byte-addressed DMEM plus generic banks of
// memory-mapped output registers and synchronised input registers.
// Loads are registered (1-cycle latency, read-before-write on the same edge);
// misaligned accesses are suppressed and flagged for one cycle.
module lsu_mmio #(
  parameter int                DMEM_BYTES  = 2048,
  parameter int                ADDR_W      = 16,
  parameter int                N_OUT       = 5,
  parameter int                N_IN        = 2,
  parameter logic [ADDR_W-1:0] OUT_BASE    = 16'h7000,
  parameter logic [ADDR_W-1:0] IN_BASE     = 16'h7800,
  parameter int                SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [31:0]           w_data,
  input  logic [2:0]            data_mode,
  output logic [31:0]           r_data,
  output logic                  misalign,
  input  logic [N_IN*32-1:0]    in_i,
  output logic [N_OUT*32-1:0]   out_o
);

  localparam int WA_W   = ADDR_W - 2;
  localparam int DW_N   = DMEM_BYTES / 4;
  localparam int DIDX_W = (DW_N > 1) ? $clog2(DW_N) : 1;
  localparam logic [WA_W-1:0] OUT_WB = OUT_BASE[ADDR_W-1:2];
  localparam logic [WA_W-1:0] IN_WB  = IN_BASE[ADDR_W-1:2];

  // Alignment rule: B never faults, H needs addr[0]==0, W (and any
  // undefined mode, which behaves as W) needs addr[1:0]==0.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

  // Little-endian byte enables for a store of size sz at byte offset a.
  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the right-aligned store data across lanes so the byte
  // enables alone pick what lands where.
  function automatic logic [31:0] st_lanes(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Shift the addressed lane(s) down and sign- or zero-extend.
  function automatic logic [31:0] ld_extend(input logic [31:0] word,
                                            input logic [2:0]  mode,
                                            input logic [1:0]  a);
    logic [31:0] sh;
    sh = word >> {a, 3'b000};
    case (mode[1:0])
      2'b00:   return mode[2] ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return mode[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  logic [31:0]        mem [DW_N];
  logic [31:0]        out_q [N_OUT];
  logic [N_IN*32-1:0] sync_q [SYNC_STAGES];
  logic [31:0]        r_data_q, r_data_d;
  logic               misalign_q, misalign_d;

  logic [WA_W-1:0]    wa;
  logic [DIDX_W-1:0]  idx;
  logic               dmem_hit;
  logic [N_OUT-1:0]   out_hit;
  logic [N_IN-1:0]    in_hit;
  logic               mis;
  logic               st_en;
  logic [3:0]         be;
  logic [31:0]        wlanes;
  logic [31:0]        rd_word;

  assign wa       = addr[ADDR_W-1:2];
  assign idx      = addr[DIDX_W+1:2];
  assign dmem_hit = (32'(addr) < DMEM_BYTES);
  assign mis      = is_misaligned(data_mode[1:0], addr[1:0]);
  assign be       = byte_en(data_mode[1:0], addr[1:0]);
  assign wlanes   = st_lanes(data_mode[1:0], w_data);
  // IN-bank and unmapped stores fall out here because they hit neither target.
  assign st_en    = w_en && !mis;

  // Address decode and read-word select; DMEM takes priority over the banks.
  always_comb begin
    out_hit = '0;
    in_hit  = '0;
    rd_word = 32'h0;
    for (int k = 0; k < N_OUT; k++)
      out_hit[k] = !dmem_hit && (wa == OUT_WB + WA_W'(k));
    for (int k = 0; k < N_IN; k++)
      in_hit[k] = !dmem_hit && (out_hit == '0) && (wa == IN_WB + WA_W'(k));
    if (dmem_hit)
      rd_word = mem[idx];
    for (int k = 0; k < N_OUT; k++)
      if (out_hit[k]) rd_word = out_q[k];
    for (int k = 0; k < N_IN; k++)
      if (in_hit[k]) rd_word = sync_q[SYNC_STAGES-1][32*k +: 32];
  end

  assign r_data_d   = mis ? 32'h0 : ld_extend(rd_word, data_mode, addr[1:0]);
  assign misalign_d = mis;

  // DMEM byte-lane writes; contents survive reset but no store lands during it.
  always_ff @(posedge clk) begin
    if (rst_n && st_en && dmem_hit)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
  end

  // Output register bank with byte-lane writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= 32'h0;
    end else begin
      for (int k = 0; k < N_OUT; k++)
        if (st_en && out_hit[k])
          for (int b = 0; b < 4; b++)
            if (be[b]) out_q[k][8*b +: 8] <= wlanes[8*b +: 8];
    end
  end

  // Multi-flop synchroniser chain for the asynchronous input words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= in_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Registered load data and misalignment flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q   <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      r_data_q   <= r_data_d;
      misalign_q <= misalign_d;
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign out_o[32*k +: 32] = out_q[k];
  end

  assign r_data   = r_data_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_lsu_mmio.sv
// tb_lsu_mmio: directed scenario bench for lsu_mmio with default parameters.
module tb_lsu_mmio;

  localparam int DMEM_BYTES = 2048;
  localparam int N_OUT = 5;
  localparam int N_IN  = 2;
  localparam logic [2:0] MB = 3'b000, MH = 3'b001, MW = 3'b010,
                         MBU = 3'b100, MHU = 3'b101, MX = 3'b011;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              w_en;
  logic [15:0]       addr;
  logic [31:0]       w_data;
  logic [2:0]        data_mode;
  logic [31:0]       r_data;
  logic              misalign;
  logic [N_IN*32-1:0]  in_i;
  logic [N_OUT*32-1:0] out_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_mem [DMEM_BYTES/4];

  lsu_mmio dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .addr(addr), .w_data(w_data),
    .data_mode(data_mode), .r_data(r_data), .misalign(misalign),
    .in_i(in_i), .out_o(out_o)
  );

  always #5 clk = ~clk;

  // One access: drive, take an edge, leave us 1ns after it with w_en low.
  task automatic do_op(input logic we, input logic [15:0] a,
                       input logic [31:0] d, input logic [2:0] m);
    w_en = we; addr = a; w_data = d; data_mode = m;
    @(posedge clk); #1;
    w_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; w_en = 1'b0; addr = 16'h0; w_data = 32'h0; data_mode = MW; in_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (r_data !== 32'h0) begin $display("FAIL rst_rdata got=%h exp=%h", r_data, 32'h0); failures++; end
    checks++; if (misalign !== 1'b0) begin $display("FAIL rst_misalign got=%b exp=0", misalign); failures++; end
    checks++; if (out_o !== '0) begin $display("FAIL rst_out got=%h exp=0", out_o); failures++; end
    rst_n = 1'b1;
    // async reset of r_data and out_o mid-cycle
    do_op(1'b1, 16'h7000, 32'h12345678, MW);
    do_op(1'b0, 16'h7000, 32'h0, MW);
    checks++; if (r_data !== 32'h12345678) begin $display("FAIL pre_rst_rdata got=%h exp=%h", r_data, 32'h12345678); failures++; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (r_data !== 32'h0) begin $display("FAIL async_rst_rdata got=%h exp=0", r_data); failures++; end
    checks++; if (out_o !== '0) begin $display("FAIL async_rst_out got=%h exp=0", out_o); failures++; end
    rst_n = 1'b1;
    // async reset of misalign, then a store held across an edge in reset is lost
    do_op(1'b1, 16'h7000, 32'h12345678, MW);
    do_op(1'b0, 16'h7001, 32'h0, MH);
    checks++; if (misalign !== 1'b1) begin $display("FAIL pre_rst_misalign got=%b exp=1", misalign); failures++; end
    w_en = 1'b1; addr = 16'h7004; w_data = 32'hFFFFFFFF; data_mode = MW;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (misalign !== 1'b0) begin $display("FAIL async_rst_misalign got=%b exp=0", misalign); failures++; end
    @(posedge clk); #1;
    checks++; if (out_o !== '0) begin $display("FAIL store_in_reset got=%h exp=0", out_o); failures++; end
    w_en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_word_out;
    do_op(1'b1, 16'h7008, 32'hDEADBEEF, MW);
    checks++; if (out_o[95:64] !== 32'hDEADBEEF) begin $display("FAIL out2 got=%h exp=%h", out_o[95:64], 32'hDEADBEEF); failures++; end
    checks++; if (out_o[63:0] !== 64'h0) begin $display("FAIL out01 got=%h exp=0", out_o[63:0]); failures++; end
    checks++; if (out_o[159:96] !== 64'h0) begin $display("FAIL out34 got=%h exp=0", out_o[159:96]); failures++; end
    do_op(1'b0, 16'h7008, 32'h0, MW);
    checks++; if (r_data !== 32'hDEADBEEF) begin $display("FAIL lw_out2 got=%h exp=%h", r_data, 32'hDEADBEEF); failures++; end
    // one past the last output register is unmapped
    do_op(1'b1, 16'h7014, 32'h55555555, MW);
    do_op(1'b0, 16'h7014, 32'h0, MW);
    checks++; if (r_data !== 32'h0) begin $display("FAIL lw_out5 got=%h exp=0", r_data); failures++; end
    checks++; if (out_o !== {64'h0, 32'hDEADBEEF, 64'h0}) begin $display("FAIL out_after_out5 got=%h", out_o); failures++; end
    // byte store into an output register touches one lane only
    do_op(1'b1, 16'h7009, 32'h000000AB, MB);
    checks++; if (out_o[95:64] !== 32'hDEADABEF) begin $display("FAIL sb_out2 got=%h exp=%h", out_o[95:64], 32'hDEADABEF); failures++; end
  endtask

  task automatic test_lanes;
    do_op(1'b1, 16'h0010, 32'h00000000, MW);
    do_op(1'b1, 16'h0013, 32'h00000080, MB);
    do_op(1'b1, 16'h0010, 32'h00001234, MH);
    do_op(1'b0, 16'h0010, 32'h0, MW);
    checks++; if (r_data !== 32'h80001234) begin $display("FAIL lw10 got=%h exp=%h", r_data, 32'h80001234); failures++; end
    do_op(1'b0, 16'h0013, 32'h0, MB);
    checks++; if (r_data !== 32'hFFFFFF80) begin $display("FAIL lb13 got=%h exp=%h", r_data, 32'hFFFFFF80); failures++; end
    do_op(1'b0, 16'h0013, 32'h0, MBU);
    checks++; if (r_data !== 32'h00000080) begin $display("FAIL lbu13 got=%h exp=%h", r_data, 32'h00000080); failures++; end
    do_op(1'b0, 16'h0012, 32'h0, MH);
    checks++; if (r_data !== 32'hFFFF8000) begin $display("FAIL lh12 got=%h exp=%h", r_data, 32'hFFFF8000); failures++; end
    do_op(1'b0, 16'h0012, 32'h0, MHU);
    checks++; if (r_data !== 32'h00008000) begin $display("FAIL lhu12 got=%h exp=%h", r_data, 32'h00008000); failures++; end
    do_op(1'b0, 16'h0010, 32'h0, MB);
    checks++; if (r_data !== 32'h00000034) begin $display("FAIL lb10 got=%h exp=%h", r_data, 32'h00000034); failures++; end
  endtask

  task automatic test_back_to_back;
    // store and load the same word on one edge: old word first, new word next
    do_op(1'b1, 16'h0010, 32'hCAFEF00D, MW);
    checks++; if (r_data !== 32'h80001234) begin $display("FAIL rbw_old got=%h exp=%h", r_data, 32'h80001234); failures++; end
    do_op(1'b0, 16'h0010, 32'h0, MW);
    checks++; if (r_data !== 32'hCAFEF00D) begin $display("FAIL rbw_new got=%h exp=%h", r_data, 32'hCAFEF00D); failures++; end
  endtask

  task automatic test_misalign;
    do_op(1'b1, 16'h0020, 32'h11111111, MW);
    checks++; if (misalign !== 1'b0) begin $display("FAIL sw20_mis got=%b exp=0", misalign); failures++; end
    do_op(1'b1, 16'h0022, 32'hAAAAAAAA, MW);
    checks++; if (misalign !== 1'b1) begin $display("FAIL sw22_mis got=%b exp=1", misalign); failures++; end
    do_op(1'b0, 16'h0020, 32'h0, MW);
    checks++; if (misalign !== 1'b0) begin $display("FAIL mis_oneshot got=%b exp=0", misalign); failures++; end
    checks++; if (r_data !== 32'h11111111) begin $display("FAIL lw20_kept got=%h exp=%h", r_data, 32'h11111111); failures++; end
    do_op(1'b0, 16'h0021, 32'h0, MH);
    checks++; if (r_data !== 32'h0) begin $display("FAIL lh21_data got=%h exp=0", r_data); failures++; end
    checks++; if (misalign !== 1'b1) begin $display("FAIL lh21_mis got=%b exp=1", misalign); failures++; end
    do_op(1'b0, 16'h0022, 32'h0, MX);
    checks++; if (misalign !== 1'b1) begin $display("FAIL undef_mode_mis got=%b exp=1", misalign); failures++; end
    do_op(1'b0, 16'h0023, 32'h0, MBU);
    checks++; if (misalign !== 1'b0 || r_data !== 32'h00000011) begin $display("FAIL lbu23 got=%b/%h exp=0/%h", misalign, r_data, 32'h00000011); failures++; end
  endtask

  task automatic test_inputs;
    w_en = 1'b0; addr = 16'h7804; data_mode = MW;
    in_i[63:32] = 32'h0000A5A5;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      checks++;
      if (e < 3 && r_data !== 32'h0) begin $display("FAIL in_early edge=%0d got=%h exp=0", e, r_data); failures++; end
      else if (e == 3 && r_data !== 32'h0000A5A5) begin $display("FAIL in_late got=%h exp=%h", r_data, 32'h0000A5A5); failures++; end
    end
    do_op(1'b1, 16'h7804, 32'hFFFFFFFF, MW);
    do_op(1'b0, 16'h7804, 32'h0, MW);
    checks++; if (r_data !== 32'h0000A5A5) begin $display("FAIL in_st_ignored got=%h exp=%h", r_data, 32'h0000A5A5); failures++; end
    do_op(1'b0, 16'h7800, 32'h0, MW);
    checks++; if (r_data !== 32'h0) begin $display("FAIL in0 got=%h exp=0", r_data); failures++; end
    do_op(1'b0, 16'h7805, 32'h0, MHU);
    checks++; if (r_data !== 32'h0) begin $display("FAIL in_mis_data got=%h exp=0", r_data); failures++; end
  endtask

  task automatic test_sweep_unmapped;
    logic [159:0] out_snap;
    for (int i = 0; i < DMEM_BYTES/4; i++) begin
      exp_mem[i] = $urandom;
      do_op(1'b1, 16'(i*4), exp_mem[i], MW);
    end
    for (int i = 0; i < DMEM_BYTES/4; i++) begin
      do_op(1'b0, 16'(i*4), 32'h0, MW);
      checks++; if (r_data !== exp_mem[i]) begin $display("FAIL sweep idx=%0d got=%h exp=%h", i, r_data, exp_mem[i]); failures++; end
    end
    out_snap = out_o;
    do_op(1'b0, 16'h5000, 32'h0, MW);
    checks++; if (r_data !== 32'h0) begin $display("FAIL lw5000 got=%h exp=0", r_data); failures++; end
    do_op(1'b1, 16'h5000, 32'hFFFFFFFF, MW);
    do_op(1'b1, 16'h0800, 32'hEEEEEEEE, MW);
    do_op(1'b0, 16'h5000, 32'h0, MW);
    checks++; if (r_data !== 32'h0) begin $display("FAIL sw5000_ignored got=%h exp=0", r_data); failures++; end
    do_op(1'b0, 16'h0800, 32'h0, MW);
    checks++; if (r_data !== 32'h0) begin $display("FAIL lw0800 got=%h exp=0", r_data); failures++; end
    do_op(1'b0, 16'h0000, 32'h0, MW);
    checks++; if (r_data !== exp_mem[0]) begin $display("FAIL no_alias got=%h exp=%h", r_data, exp_mem[0]); failures++; end
    checks++; if (out_o !== out_snap) begin $display("FAIL unmapped_out got=%h exp=%h", out_o, out_snap); failures++; end
  endtask

  initial begin
    test_reset();
    test_word_out();
    test_lanes();
    test_back_to_back();
    test_misalign();
    test_inputs();
    test_sweep_unmapped();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mmio.md
# lsu_mmio

Parametrised load/store unit for the pipelined core's MEM stage. It replaces the fixed SW/KEY/LEDR/LEDG/HEX/LCD map with generic banks of N_IN input and N_OUT output registers. It serves byte, halfword and word loads and stores, with sign or zero extension, against a byte-addressed DMEM and those register banks. Reads are registered with 1-cycle latency; misaligned accesses are trapped and flagged.

## Interface
- DMEM_BYTES, 2048, DMEM size in bytes; power of two, ≥ 4
- ADDR_W, 16, byte address width
- N_OUT, 5, number of 32-bit output registers, 1..16
- N_IN, 2, number of 32-bit input registers, 1..16
- OUT_BASE, 16'h7000, base of the output bank; register k at OUT_BASE + 4k
- IN_BASE, 16'h7800, base of the input bank; register k at IN_BASE + 4k
- SYNC_STAGES, 2, synchroniser depth on inputs, ≥ 2

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- w_en  in  1  store strobe, sampled on rising clk
- addr  in  ADDR_W  byte address
- w_data  in  32  store data, right-aligned
- data_mode  in  3  RV funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- r_data  out  32  registered, extended load data
- misalign  out  1  registered 1-cycle flag for a misaligned access
- in_i  in  N_IN*32  asynchronous input words, word k at [32k+31:32k]
- out_o  out  N_OUT*32  output register contents, same packing

## Operation
- Decode (combinational on addr):
  - DMEM hit when addr < DMEM_BYTES.
  - OUT hit k when addr[ADDR_W-1:2] == (OUT_BASE>>2) + k, k < N_OUT.
  - IN hit k likewise from IN_BASE.
  - Anything else is unmapped.
- Alignment:
  - H/HU is misaligned when addr[0] == 1.
  - W is misaligned when addr[1:0] != 0.
  - Undefined data_mode codes (011, 110, 111) are treated as W.
- Store (w_en = 1, aligned, mapped, not an IN hit):
  - Byte enables are derived from data_mode[1:0] and addr[1:0], little-endian.
  - B writes w_data[7:0] into lane addr[1:0].
  - H writes w_data[15:0] into lanes addr[1]*2 .. +1.
  - W writes all four lanes.
  - Only the enabled lanes of the DMEM word or OUT register change.
- Suppressed stores: misaligned, unmapped or IN-bank stores change no state.
- Load (every cycle, regardless of w_en):
  - Select the 32-bit word: DMEM word, OUT register, synchronised IN word, or 0 if unmapped.
  - Extract the lane(s) at addr[1:0].
  - B/H sign-extend; BU/HU zero-extend.
  - Register the result into r_data.
  - A misaligned load registers r_data = 0.
- Input synchronisers:
  - Each in_i bit passes through a SYNC_STAGES flop chain.
  - Reads return the last stage.
- misalign: registered each cycle as (alignment error) for both loads and stores, independent of mapping.

## Timing
- Reset (rst_n = 0, async):
  - r_data = 0, misalign = 0, out_o = 0.
  - All synchroniser flops = 0.
  - DMEM contents are not reset.
- Store commits on the rising edge where w_en = 1; out_o reflects it immediately after that edge.
- Load latency 1: r_data after edge n reflects addr/data_mode held before edge n.
- Same-edge read and write to the same word returns the OLD word (read-before-write). The new value is visible one edge later.
- in_i change appears in r_data no earlier than SYNC_STAGES + 1 edges after it is stable.
- Reset asserted mid-store: the store is lost; out_o returns to 0.
- Address wrap: DMEM is not aliased. An addr ≥ DMEM_BYTES that matches no bank reads 0 and ignores writes.

## Test plan
- Reset: drive rst_n = 0 mid-cycle -> r_data, misalign and all out_o go to 0 asynchronously, before the next edge.
- Word store/load to OUT register 2 (addr 0x7008):
  - Store W 0xDEADBEEF -> out_o[95:64] = 0xDEADBEEF.
  - Load W -> r_data = 0xDEADBEEF one edge later.
  - Other out_o words stay 0.
- Byte/half lanes in DMEM:
  - Setup: store W 0x00000000 at 0x10, then store B 0x80 at 0x13 and store H 0x1234 at 0x10.
  - LW 0x10 -> 0x80001234.
  - LB 0x13 -> 0xFFFFFF80.
  - LBU 0x13 -> 0x00000080.
  - LH 0x12 -> 0xFFFF8000.
- Misalign:
  - SW 0xAAAAAAAA at 0x22 -> misalign = 1 for one cycle, and LW 0x20 still returns the prior value.
  - LH 0x21 -> r_data = 0, misalign = 1.
- Inputs:
  - Set in_i word 1 = 0x0000A5A5.
  - LW IN_BASE+4 reads the old value until SYNC_STAGES + 1 edges later, then 0x0000A5A5.
  - SW to IN_BASE+4 does not change it.
- Sweep and unmapped:
  - Store random words to every DMEM word 0..DMEM_BYTES-4 step 4, then read back -> all match.
  - LW 0x5000 -> 0.
  - SW 0x5000 changes nothing.
